// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: slave address map,
// FSM state encoding and the address-match helper used by the decoder.
package mmio_pkg;

    localparam int NUM_SLAVES_DEFAULT     = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 15;

    // Slave order: 0 = data RAM, 1 = led_mmap, 2 = switch input, 3 = timer
    localparam logic [31:0] SLAVE_BASE [NUM_SLAVES_DEFAULT] = '{
        32'h0000_0000, 32'h8000_0000, 32'h8000_0010, 32'h8000_0020
    };
    localparam logic [31:0] SLAVE_MASK [NUM_SLAVES_DEFAULT] = '{
        32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic logic slave_match(input logic [31:2] addr, input int idx);
        return ((addr & SLAVE_MASK[idx][31:2]) == SLAVE_BASE[idx][31:2]);
    endfunction

endpackage

// File: rtl/mmio_decoder.sv
// Combinational address decoder: reports whether any slave claims the word
// address and which one, with the lowest index winning on overlap.
module mmio_decoder
    import mmio_pkg::*;
#(
    parameter int NUM_SLAVES = NUM_SLAVES_DEFAULT,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [31:2]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    // Scan from the top index down so the lowest matching slave is kept last
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            hit = hit | slave_match(addr, i);
            sel = slave_match(addr, i) ? SEL_W'(i) : sel;
        end
    end

endmodule

// File: rtl/mmio_reg.sv
// Generic enabled register with synchronous active-high clear.
module mmio_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Core data-port to memory-mapped peripheral bridge: decodes, strobes one
// slave, waits for its ready with a timeout, and reports bus errors.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int NUM_SLAVES     = NUM_SLAVES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    input  logic [31:2]              cpu_addr,
    input  logic [31:0]              cpu_wd,
    output logic [31:0]              cpu_rd,
    output logic                     cpu_stall,
    output logic                     cpu_err,
    output logic [31:2]              err_addr,
    output logic [NUM_SLAVES-1:0]    s_re,
    output logic [NUM_SLAVES-1:0]    s_we,
    output logic [31:2]              s_addr,
    output logic [31:0]              s_wd,
    input  logic [NUM_SLAVES*32-1:0] s_rd,
    input  logic [NUM_SLAVES-1:0]    s_ready
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [31:2]        addr_r;
    logic [31:0]        wd_r;
    op_e                op_r;
    logic [SEL_W-1:0]   sel_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               latch_s;
    logic               dec_hit_s;
    logic [SEL_W-1:0]   dec_sel_s;
    logic               rd_en_s;
    logic [31:0]        rd_d_s;
    logic [31:0]        rd_q_r;
    logic               err_en_s;

    mmio_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_W      (SEL_W)
    ) u_dec (
        .addr (cpu_addr),
        .hit  (dec_hit_s),
        .sel  (dec_sel_s)
    );

    mmio_reg #(.WIDTH(32)) u_rd_q (
        .clk   (clk),
        .reset (reset),
        .en    (rd_en_s),
        .d     (rd_d_s),
        .q     (rd_q_r)
    );

    mmio_reg #(.WIDTH(30)) u_err_addr (
        .clk   (clk),
        .reset (reset),
        .en    (err_en_s),
        .d     (addr_r),
        .q     (err_addr)
    );

    assign s_addr = addr_r;
    assign s_wd   = wd_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture and timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r <= '0;
            wd_r   <= '0;
            op_r   <= OP_READ;
            sel_r  <= '0;
            cnt_r  <= '0;
        end else begin
            if (latch_s) begin
                addr_r <= cpu_addr;
                wd_r   <= cpu_wd;
                op_r   <= cpu_we ? OP_WRITE : OP_READ;
                sel_r  <= dec_sel_s;
            end else begin
                addr_r <= addr_r;
                wd_r   <= wd_r;
                op_r   <= op_r;
                sel_r  <= sel_r;
            end
            cnt_r <= cnt_nxt_s;
        end
    end

    // Next-state, strobes and core-side handshake
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        rd_en_s     = 1'b0;
        rd_d_s      = '0;
        err_en_s    = 1'b0;
        cpu_stall   = 1'b0;
        cpu_err     = 1'b0;
        cpu_rd      = '0;
        s_re        = '0;
        s_we        = '0;
        case (state_r)
            IDLE: begin
                cpu_stall = cpu_re | cpu_we;
                if (cpu_re | cpu_we) begin
                    latch_s     = 1'b1;
                    state_nxt_s = dec_hit_s ? ACCESS : ERR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                cpu_stall = 1'b1;
                if (op_r == OP_WRITE) begin
                    s_we[sel_r] = 1'b1;
                end else begin
                    s_re[sel_r] = 1'b1;
                end
                if (s_ready[sel_r]) begin
                    rd_en_s     = 1'b1;
                    rd_d_s      = (op_r == OP_WRITE) ? 32'h0000_0000 : s_rd[sel_r*32 +: 32];
                    cnt_nxt_s   = '0;
                    state_nxt_s = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ERR;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    state_nxt_s = ACCESS;
                end
            end
            RESP: begin
                cpu_rd      = rd_q_r;
                state_nxt_s = IDLE;
            end
            ERR: begin
                cpu_err     = 1'b1;
                err_en_s    = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge with simple RAM/LED/switch/timer
// slave models and a queue of expected access outcomes.
module tb_mmio_bridge;
    import mmio_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cpu_re = 1'b0;
    logic            cpu_we = 1'b0;
    logic [31:2]     cpu_addr = '0;
    logic [31:0]     cpu_wd = '0;
    logic [31:0]     cpu_rd;
    logic            cpu_stall;
    logic            cpu_err;
    logic [31:2]     err_addr;
    logic [N-1:0]    s_re;
    logic [N-1:0]    s_we;
    logic [31:2]     s_addr;
    logic [31:0]     s_wd;
    logic [N*32-1:0] s_rd;
    logic [N-1:0]    s_ready;

    logic [31:0] led_q = 32'h0000_0000;
    logic [3:0]  timer_cnt = 4'd0;
    logic        sw_ready = 1'b0;
    logic        timer_ready;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [7:0]  stall;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    logic        obs_done;
    logic [31:0] obs_rd;
    logic        obs_err;
    logic        obs_err_after;
    logic [31:2] obs_err_addr;
    int          obs_stall;
    int          re_cnt[N];
    int          we_cnt[N];

    mmio_bridge #(.NUM_SLAVES(N), .TIMEOUT_CYCLES(15)) u_dut (
        .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
        .cpu_stall(cpu_stall), .cpu_err(cpu_err), .err_addr(err_addr),
        .s_re(s_re), .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd),
        .s_rd(s_rd), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    // Slave models: RAM and LED always ready, switch never (unless enabled),
    // timer ready on the third strobed cycle
    assign timer_ready = (s_re[3] | s_we[3]) && (timer_cnt == 4'd2);
    assign s_ready = {timer_ready, sw_ready, 1'b1, 1'b1};
    assign s_rd = {32'h1234_5678, 32'h0000_0F0F, led_q, 32'h5A5A_0000};

    always @(posedge clk) begin
        if (s_we[1] && s_ready[1]) led_q <= s_wd;
        timer_cnt <= (s_re[3] | s_we[3]) ? timer_cnt + 4'd1 : 4'd0;
    end

    task automatic run_access(input logic re, input logic we,
                              input logic [31:0] addr, input logic [31:0] wd);
        obs_done  = 1'b0;
        obs_stall = 0;
        obs_rd    = '0;
        obs_err   = 1'b0;
        for (int k = 0; k < N; k++) begin re_cnt[k] = 0; we_cnt[k] = 0; end
        @(posedge clk); #1;
        cpu_re = re; cpu_we = we; cpu_addr = addr[31:2]; cpu_wd = wd;
        for (int c = 0; c < 40 && !obs_done; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                re_cnt[k] += int'(s_re[k]);
                we_cnt[k] += int'(s_we[k]);
            end
            if (cpu_stall) obs_stall++;
            else begin obs_rd = cpu_rd; obs_err = cpu_err; obs_done = 1'b1; end
        end
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        obs_err_after = cpu_err;
        obs_err_addr  = err_addr;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({cpu_stall, cpu_err, s_re, s_we} !== 10'b0 || cpu_rd !== 32'h0 || err_addr !== 30'h0) begin
            miscompares++;
            $display("FAIL reset: stall=%b err=%b re=%b we=%b rd=%h ea=%h, required all zero",
                     cpu_stall, cpu_err, s_re, s_we, cpu_rd, err_addr);
        end
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_addr = 30'h2000_0000;
        #1;
        vectors++;
        if (cpu_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_stall: got %b required 1", cpu_stall);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        cpu_re = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_access(input string name, input logic [29:0] ea_exp, input logic chk_ea);
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (!obs_done) begin
            miscompares++;
            $display("FAIL %s_timeout: stall never dropped within 40 cycles", name);
        end
        vectors++;
        if (obs_rd !== e.rd || obs_err !== e.err || obs_stall !== int'(e.stall)) begin
            miscompares++;
            $display("FAIL %s: rd=%h err=%b stall=%0d, required rd=%h err=%b stall=%0d",
                     name, obs_rd, obs_err, obs_stall, e.rd, e.err, e.stall);
        end
        vectors++;
        if (obs_err_after !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_err_pulse: err still %b after one cycle, required 0", name, obs_err_after);
        end
        if (chk_ea) begin
            vectors++;
            if (obs_err_addr !== ea_exp) begin
                miscompares++;
                $display("FAIL %s_err_addr: got %h required %h", name, obs_err_addr, ea_exp);
            end
        end
    endtask

    task automatic check_strobes(input string name, input int idx, input int re_exp, input int we_exp);
        int re_tot, we_tot;
        re_tot = 0; we_tot = 0;
        for (int k = 0; k < N; k++) begin re_tot += re_cnt[k]; we_tot += we_cnt[k]; end
        vectors++;
        if (re_cnt[idx] !== re_exp || we_cnt[idx] !== we_exp || re_tot !== re_exp || we_tot !== we_exp) begin
            miscompares++;
            $display("FAIL %s_strobes: slave%0d re=%0d we=%0d (total re=%0d we=%0d), required re=%0d we=%0d",
                     name, idx, re_cnt[idx], we_cnt[idx], re_tot, we_tot, re_exp, we_exp);
        end
    endtask

    task automatic test_led_store_load;
        exp_q.push_back('{rd: 32'h0, err: 1'b0, stall: 8'd2});
        run_access(1'b0, 1'b1, 32'h8000_0000, 32'h0000_00A5);
        check_access("led_store", 30'h0, 1'b0);
        check_strobes("led_store", 1, 0, 1);
        exp_q.push_back('{rd: 32'h0000_00A5, err: 1'b0, stall: 8'd2});
        run_access(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        check_access("led_load", 30'h0, 1'b0);
        check_strobes("led_load", 1, 1, 0);
    endtask

    task automatic test_both_strobes;
        exp_q.push_back('{rd: 32'h0, err: 1'b0, stall: 8'd2});
        run_access(1'b1, 1'b1, 32'h8000_0000, 32'h0000_00FF);
        check_access("re_we_write", 30'h0, 1'b0);
        check_strobes("re_we_write", 1, 0, 1);
        exp_q.push_back('{rd: 32'h0000_00FF, err: 1'b0, stall: 8'd2});
        run_access(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        check_access("re_we_readback", 30'h0, 1'b0);
    endtask

    task automatic test_unmapped;
        exp_q.push_back('{rd: 32'h0, err: 1'b1, stall: 8'd1});
        run_access(1'b1, 1'b0, 32'h4000_0000, 32'h0);
        check_access("unmapped", 30'h1000_0000, 1'b1);
        check_strobes("unmapped", 0, 0, 0);
        exp_q.push_back('{rd: 32'h5A5A_0000, err: 1'b0, stall: 8'd2});
        run_access(1'b1, 1'b0, 32'h0000_3FFC, 32'h0);
        check_access("ram_top", 30'h1000_0000, 1'b1);
        check_strobes("ram_top", 0, 1, 0);
        exp_q.push_back('{rd: 32'h0, err: 1'b1, stall: 8'd1});
        run_access(1'b0, 1'b1, 32'h0000_4000, 32'h1);
        check_access("ram_past_end", 30'h0000_1000, 1'b1);
        check_strobes("ram_past_end", 0, 0, 0);
        exp_q.push_back('{rd: 32'h0, err: 1'b1, stall: 8'd1});
        run_access(1'b1, 1'b0, 32'h8000_0030, 32'h0);
        check_access("io_gap", 30'h2000_000C, 1'b1);
    endtask

    task automatic test_slow_timer;
        exp_q.push_back('{rd: 32'h1234_5678, err: 1'b0, stall: 8'd4});
        run_access(1'b1, 1'b0, 32'h8000_0020, 32'h0);
        check_access("timer_slow", 30'h2000_000C, 1'b1);
        check_strobes("timer_slow", 3, 3, 0);
    endtask

    task automatic test_timeout;
        exp_q.push_back('{rd: 32'h0, err: 1'b1, stall: 8'd16});
        run_access(1'b1, 1'b0, 32'h8000_0010, 32'h0);
        check_access("sw_timeout", 30'h2000_0004, 1'b1);
        check_strobes("sw_timeout", 2, 15, 0);
        sw_ready = 1'b1;
        exp_q.push_back('{rd: 32'h0000_0F0F, err: 1'b0, stall: 8'd2});
        run_access(1'b1, 1'b0, 32'h8000_0010, 32'h0);
        check_access("sw_ready", 30'h2000_0004, 1'b1);
        sw_ready = 1'b0;
    endtask

    task automatic test_reset_mid_access;
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 30'h2000_0008; cpu_wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (s_we !== 4'b1000) begin
            miscompares++;
            $display("FAIL slow_write_strobe: s_we=%b required 1000", s_we);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        vectors++;
        if (u_dut.state_r !== IDLE || s_we !== 4'b0 || s_re !== 4'b0 ||
            u_dut.rd_q_r !== 32'h0 || err_addr !== 30'h0 || cpu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_access: state=%0d we=%b re=%b rd_q=%h ea=%h stall=%b, required 0/0/0/0/0/0",
                     u_dut.state_r, s_we, s_re, u_dut.rd_q_r, err_addr, cpu_stall);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_led_store_load();
        test_both_strobes();
        test_unmapped();
        test_slow_timer();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Sits between the core's data-memory port and the memory-mapped peripherals (data RAM, led_mmap, switch input, timer). Decodes each load/store address to one slave and drives that slave's re/we/addr/wd. Registers the returned read data and stalls the core until the access completes. Unmapped addresses and slaves that never respond produce a one-cycle bus error, and the faulting address is latched.

Parameters:
NUM_SLAVES, 4, number of slave ports; the address map comes from mmio_pkg.
TIMEOUT_CYCLES, 15, maximum number of ACCESS cycles to wait for s_ready before a timeout error.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cpu_re  input  1  load request; held by the core while cpu_stall=1
cpu_we  input  1  store request; held by the core while cpu_stall=1
cpu_addr  input  [31:2]  word address
cpu_wd  input  32  store data
cpu_rd  output  32  load data, valid in the RESP cycle
cpu_stall  output  1  core must hold its request and pipeline
cpu_err  output  1  one-cycle bus-error pulse
err_addr  output  [31:2]  address of the most recent error (sticky)
s_re  output  NUM_SLAVES  per-slave read strobe
s_we  output  NUM_SLAVES  per-slave write strobe
s_addr  output  [31:2]  latched address, shared by all slaves
s_wd  output  32  latched write data, shared by all slaves
s_rd  input  NUM_SLAVES*32  slave read data, flattened; slave i occupies bits [32i+31:32i]
s_ready  input  NUM_SLAVES  slave completes the access this cycle; tie high for single-cycle slaves such as led_mmap

Behaviour:
- Reset values:
  - state=IDLE.
  - rd_q=0, err_addr=0, timeout counter=0.
  - s_re, s_we, cpu_err, cpu_rd all 0.
  - cpu_stall=0 unless a request is present.
- Decode, done by mmio_decoder:
  - Slave i hits when (cpu_addr & SLAVE_MASK[i]) == SLAVE_BASE[i], comparing bits [31:2].
  - If several slaves hit, the lowest index wins.
  - If no slave hits, the access is a miss.
- IDLE:
  - cpu_stall = cpu_re | cpu_we (combinational).
  - On a request, latch addr, wd, op and sel. Op is WRITE if cpu_we=1, otherwise READ; cpu_we has priority when both strobes are high.
  - Next state is ACCESS on a hit, ERR on a miss.
- ACCESS:
  - cpu_stall=1.
  - s_re[sel] is asserted for a READ, s_we[sel] for a WRITE. All other strobes are 0.
  - s_addr and s_wd are held stable from the latched values.
  - If s_ready[sel]=1: capture s_rd[sel] into rd_q (READ only; a WRITE captures 0), go to RESP, clear the counter.
  - Otherwise the counter increments. If the counter reaches TIMEOUT_CYCLES-1 without s_ready, go to ERR.
  - Slaves commit a write on the cycle where s_ready=1. A ready-tied slave therefore sees exactly one we cycle.
- RESP:
  - cpu_stall=0 and cpu_rd=rd_q for one cycle, then go to IDLE.
  - The core advances in this cycle, so its next request is seen in the following IDLE cycle.
  - Minimum access time is 3 cycles (IDLE, ACCESS, RESP).
- ERR:
  - cpu_stall=0, cpu_err=1, cpu_rd=0 for one cycle.
  - err_addr is updated from the latched addr at this edge.
  - Next state is IDLE. No slave strobe is asserted in this state.
- cpu_rd is 0 in every state other than RESP.
- Reset asserted mid-access: at the next edge the state is IDLE and all strobes are 0. A pending write is abandoned, and rd_q and err_addr are cleared.
- s_ready from a non-selected slave is ignored.
- The timeout counter is 4 bits wide and sized from TIMEOUT_CYCLES.

Decomposition:
- mmio_pkg holds:
  - NUM_SLAVES_DEFAULT.
  - SLAVE_BASE and SLAVE_MASK arrays: RAM 0x0000_0000 / 0xFFFF_C000; LED 0x8000_0000 / 0xFFFF_FFF0; SW 0x8000_0010 / 0xFFFF_FFF0; TIMER 0x8000_0020 / 0xFFFF_FFF0.
  - The state enum {IDLE, ACCESS, RESP, ERR}.
- Sub-module mmio_decoder (combinational): inputs addr; outputs hit and sel index.
- rd_q and err_addr reuse the existing register module.

Test Plan:
1. Store 0x0000_00A5 to 0x8000_0000, then load from 0x8000_0000 with the led_mmap model (ready tied high):
   - s_we[1] high for exactly 1 cycle.
   - Load returns 0x0000_00A5 in the RESP cycle.
   - cpu_stall is high for 2 cycles per access.
2. Load from 0x4000_0000 (unmapped):
   - No slave strobe is asserted.
   - cpu_err pulses 1 cycle and cpu_rd=0.
   - err_addr = 0x4000_0000>>2.
3. Timer slave asserts s_ready on the 3rd ACCESS cycle with data 0x1234_5678:
   - cpu_stall is high for 4 cycles.
   - cpu_rd=0x1234_5678 in RESP.
   - s_re[3] is held high for all 3 ACCESS cycles.
4. SW slave never asserts ready:
   - Timeout after 15 ACCESS cycles.
   - cpu_err pulses 1 cycle.
   - err_addr = 0x8000_0010>>2.
5. Reset asserted on the 2nd ACCESS cycle of a slow write:
   - Next cycle: state IDLE, all s_we=0, rd_q=0, err_addr=0.
6. cpu_re and cpu_we both high to 0x8000_0000 with wd=0xFF:
   - Treated as a write: s_we[1]=1, s_re[1]=0.
   - cpu_rd=0 in RESP.
